pipe_ctrl_v2: RTL and testbench
===============================

// Module: pipe_ctrl_v2
// PURPOSE
//  Parametrised pipeline stall/flush controller; successor of the fixed 6-stage ctrl block.
//  - Builds a per-stage stall vector from N per-stage stall requests.
//  - Sequences exception flushes through an FSM. A flush waits for any outstanding bus transaction to drain.
//  - Provides a saturating stall-cycle counter and a stall watchdog.
//  - Sits beside the pipeline, driving PC/IF/ID/EX/MEM/WB stall and flush, and the redirect PC.
// PARAMETERS
//  NSTAGES      6        stages incl. PC (bit0=PC ... bit NSTAGES-1=WB)
//  VEC_INT      32'h20   interrupt vector
//  VEC_GEN      32'h40   general exception vector (syscall/invalid/trap/ov/other)
//  FLUSH_CYCLES 1        cycles flush_o is held (>=1)
//  CNT_W        16       stall counter width
//  TIMEOUT      1024     consecutive-stall watchdog limit; 0 disables
// PORTS
//  clk           in   1        clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  stall_req_i   in   NSTAGES  bit i: stage i requests stall (bit0 unused)
//  bus_busy_i    in   1        memory/bus transaction outstanding, must not be flushed
//  excepttype_i  in   32       exception cause from MEM; nonzero = exception
//  cp0_epc_i     in   32       EPC, used for eret (cause 32'he)
//  perf_clr_i    in   1        synchronous clear of stall_cnt_o
//  stall_o       out  NSTAGES  per-stage stall
//  flush_o       out  1        pipeline flush
//  new_pc_o      out  32       redirect PC, valid while flush_o=1, else 0
//  stall_cnt_o   out  CNT_W    saturating count of cycles with stall_o[0]=1 in IDLE
//  timeout_o     out  1        one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0; vec_q 0. Reset mid-flush/drain aborts immediately.
//  Stall vector (IDLE, no exception), combinational same cycle:
//   - k = highest i with stall_req_i[i]=1; stall_o[j]=1 for j<=k, else 0.
//   - Special case: if k==1 (IF), stall_o = bits[2:0]=1, so ID is held with IF.
//   - No requests -> stall_o=0.
//  Vector map (evaluated at detection):
//   - 32'h1 -> VEC_INT.
//   - 32'he -> cp0_epc_i, sampled in the detect cycle.
//   - Any other nonzero cause -> VEC_GEN.
//  FSM states: IDLE, DRAIN, FLUSH.
//   IDLE:
//    - excepttype_i!=0 -> capture vector into vec_q; stall_o=all-ones this cycle; flush_o=0.
//    - Next state: DRAIN if bus_busy_i, else FLUSH.
//    - Exception has priority over stall requests.
//   DRAIN:
//    - stall_o=all-ones, flush_o=0.
//    - Move to FLUSH the cycle after bus_busy_i is sampled 0.
//    - New excepttype_i is ignored (vec_q held).
//   FLUSH:
//    - flush_o=1, new_pc_o=vec_q, stall_o=0.
//    - Held FLUSH_CYCLES cycles (down-counter), then IDLE.
//    - excepttype_i is ignored: it comes from flushed instructions.
//   Latency: exception detected in cycle N with bus idle -> flush_o high in N+1..N+FLUSH_CYCLES.
//  Stall counter:
//   - +1 per IDLE cycle with stall_o[0]=1; saturates at 2^CNT_W-1, no wrap.
//   - perf_clr_i wins over increment in the same cycle.
//  Watchdog:
//   - Counts consecutive IDLE cycles with any stall_req_i.
//   - Resets on a request-free cycle or leaving IDLE.
//   - On reaching TIMEOUT: timeout_o=1 for one cycle, then counter restarts from 0.
//   - Informational only; does not alter stall_o.
// STRUCTURE
//  pipe_ctrl_pkg: state enum (IDLE/DRAIN/FLUSH), cause constants EXC_INT=1, EXC_SYS=8, EXC_RI=a, EXC_OV=c, EXC_TR=d, EXC_ERET=e.
//  Sub-module sat_counter #(W): en/clr/saturating; used for stall_cnt_o and the watchdog.
//  Top: priority encoder for stall_req_i, FSM, vec_q register, flush down-counter.
// TESTING
//  1 Reset:
//    - rst_n low with stall_req_i=6'b111110 -> all outputs 0.
//    - Release -> stall_o=6'b111111 same cycle.
//  2 Stall priority:
//    - req bit4 (MEM) -> 6'b011111; bit3 (EX) -> 6'b001111; bit2 (ID) -> 6'b000111.
//    - bit1 (IF) alone -> 6'b000111.
//  3 Syscall with bus idle:
//    - excepttype=8 at N -> stall_o=all-ones at N.
//    - flush_o=1, new_pc_o=32'h40 at N+1; back to IDLE at N+2 (FLUSH_CYCLES=1).
//  4 Eret during bus busy:
//    - excepttype=e, epc=32'hbfc0_0100, bus_busy for 3 cycles.
//    - Expect stall all-ones, no flush during drain.
//    - flush_o with new_pc=bfc0_0100 the cycle after bus_busy falls.
//    - epc changing during drain is ignored.
//  5 Back-to-back:
//    - Interrupt (1) in IDLE, then cause c asserted during FLUSH.
//    - Only one flush to 32'h20; cause c is ignored.
//  6 Counters:
//    - CNT_W=4, continuous stall 20 cycles -> stall_cnt_o saturates at 15.
//    - perf_clr_i -> 0 next cycle.
//    - TIMEOUT=8 -> timeout_o pulses at cycles 8 and 16.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types, exception cause codes and the redirect-vector mapping
// for the pipeline stall/flush controller.
`timescale 1ns/1ps
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FLUSH
    } state_t;

    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    // Interrupts and eret have dedicated targets; every other cause shares one vector.
    function automatic logic [31:0] map_vector(input logic [31:0] cause,
                                               input logic [31:0] epc,
                                               input logic [31:0] vec_int,
                                               input logic [31:0] vec_gen);
        case (cause)
            EXC_INT:  return vec_int;
            EXC_ERET: return epc;
            default:  return vec_gen;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_v2_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
`timescale 1ns/1ps
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments and an async reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl_v2.sv
// Pipeline stall/flush controller: per-stage stall vector, exception flush
// sequencing behind outstanding bus traffic, stall statistics and watchdog.
`timescale 1ns/1ps
module pipe_ctrl_v2
    import pipe_ctrl_pkg::*;
#(
    parameter int          NSTAGES      = 6,
    parameter logic [31:0] VEC_INT      = 32'h20,
    parameter logic [31:0] VEC_GEN      = 32'h40,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16,
    parameter int          TIMEOUT      = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSTAGES-1:0] stall_req_i,
    input  logic               bus_busy_i,
    input  logic [31:0]        excepttype_i,
    input  logic [31:0]        cp0_epc_i,
    input  logic               perf_clr_i,
    output logic [NSTAGES-1:0] stall_o,
    output logic               flush_o,
    output logic [31:0]        new_pc_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic               timeout_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state_q, state_d;
    logic [31:0]        vec_q;
    logic [FC_W-1:0]    flush_cnt_q;
    logic [NSTAGES-1:0] req_stall;
    int                 top_req;
    logic               exc;
    logic               any_req;
    logic               idle;

    assign exc     = |excepttype_i;
    assign any_req = |stall_req_i;
    assign idle    = (state_q == ST_IDLE);

    // Stall everything up to the highest requesting stage; an IF stall also holds ID.
    always_comb begin
        top_req   = 0;
        req_stall = '0;
        for (int i = 1; i < NSTAGES; i++) begin
            if (stall_req_i[i]) top_req = i;
        end
        if (top_req == 1) top_req = 2;
        if (top_req != 0) begin
            for (int j = 0; j < NSTAGES; j++) begin
                req_stall[j] = (j <= top_req);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (exc) state_d = bus_busy_i ? ST_DRAIN : ST_FLUSH;
            ST_DRAIN: if (!bus_busy_i) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_cnt_q == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, not just from the next edge.
    always_comb begin
        stall_o  = '0;
        flush_o  = 1'b0;
        new_pc_o = '0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE:  stall_o = exc ? {NSTAGES{1'b1}} : req_stall;
                ST_DRAIN: stall_o = {NSTAGES{1'b1}};
                ST_FLUSH: begin
                    flush_o  = 1'b1;
                    new_pc_o = vec_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else if (idle && exc) begin
            vec_q <= map_vector(excepttype_i, cp0_epc_i, VEC_INT, VEC_GEN);
        end
    end

    // Preloaded outside FLUSH so the first flush cycle already sees the full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= '0;
        end else if (state_q != ST_FLUSH) begin
            flush_cnt_q <= FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (idle && stall_o[0]),
        .clr   (perf_clr_i),
        .cnt   (stall_cnt_o)
    );

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WD_W-1:0] wd_cnt;
            logic            wd_run;
            logic            wd_hit;

            assign wd_run    = idle && any_req;
            assign wd_hit    = wd_run && (wd_cnt == WD_W'(TIMEOUT - 1));
            assign timeout_o = rst_n && wd_hit;

            sat_counter #(.W(WD_W)) u_wd_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (wd_run),
                .clr   (!wd_run || wd_hit),
                .cnt   (wd_cnt)
            );
        end else begin : g_no_wd
            assign timeout_o = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Directed bench for pipe_ctrl_v2: reset, stall priority table, flush
// sequences (idle bus, drain, back-to-back), counters and watchdog.
`timescale 1ns/1ps
module tb_pipe_ctrl_v2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall_req_i;
    logic        bus_busy_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        perf_clr_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [3:0]  stall_cnt_o;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] req;
        logic [5:0] exp_stall;
    } stall_vec_t;

    stall_vec_t vecs [8];

    always #5 clk = ~clk;

    pipe_ctrl_v2 #(
        .NSTAGES      (6),
        .VEC_INT      (32'h20),
        .VEC_GEN      (32'h40),
        .FLUSH_CYCLES (1),
        .CNT_W        (4),
        .TIMEOUT      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_req_i  (stall_req_i),
        .bus_busy_i   (bus_busy_i),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .perf_clr_i   (perf_clr_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o),
        .stall_cnt_o  (stall_cnt_o),
        .timeout_o    (timeout_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Move to 1 ns after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_flush(input string name, input logic exp_flush,
                               input logic [31:0] exp_pc, input logic [5:0] exp_stall);
        check({name, ".flush"}, 32'(flush_o), 32'(exp_flush));
        check({name, ".pc"}, new_pc_o, exp_pc);
        check({name, ".stall"}, 32'(stall_o), 32'(exp_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        vecs[0] = '{6'b010000, 6'b011111};
        vecs[1] = '{6'b001000, 6'b001111};
        vecs[2] = '{6'b000100, 6'b000111};
        vecs[3] = '{6'b000010, 6'b000111};
        vecs[4] = '{6'b000000, 6'b000000};
        vecs[5] = '{6'b100000, 6'b111111};
        vecs[6] = '{6'b010010, 6'b011111};
        vecs[7] = '{6'b000110, 6'b000111};

        rst_n        = 1'b0;
        stall_req_i  = 6'b111110;
        bus_busy_i   = 1'b0;
        excepttype_i = 32'h0;
        cp0_epc_i    = 32'h0;
        perf_clr_i   = 1'b0;

        // Reset holds every output low even with stall requests present.
        #12;
        check_flush("reset", 1'b0, 32'h0, 6'b000000);
        check("reset.cnt", 32'(stall_cnt_o), 32'h0);
        check("reset.timeout", 32'(timeout_o), 32'h0);

        // Release and keep stalling: cycle c has count min(c-1,15), watchdog fires at 8 and 16.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        check("release.stall", 32'(stall_o), 32'h3f);
        for (int c = 1; c <= 20; c++) begin
            check($sformatf("sat.cnt[%0d]", c), 32'(stall_cnt_o), (c - 1 > 15) ? 32'd15 : 32'(c - 1));
            check($sformatf("wd.timeout[%0d]", c), 32'(timeout_o), 32'((c == 8) || (c == 16)));
            @(posedge clk);
            #2;
        end
        check("sat.hold", 32'(stall_cnt_o), 32'd15);
        perf_clr_i = 1'b1;
        cyc();
        perf_clr_i = 1'b0;
        settle();
        check("perf_clr", 32'(stall_cnt_o), 32'd0);
        cyc();
        stall_req_i = 6'b000000;
        settle();
        check("cnt_after_clr", 32'(stall_cnt_o), 32'd1);

        // Stall priority encoding in IDLE.
        for (int i = 0; i < 8; i++) begin
            cyc();
            stall_req_i = vecs[i].req;
            settle();
            check($sformatf("prio[%0d] req=%b", i, vecs[i].req), 32'(stall_o), 32'(vecs[i].exp_stall));
        end
        cyc();
        stall_req_i = 6'b000000;

        // Syscall with bus idle: flush at N+1, back in IDLE at N+2.
        cyc();
        excepttype_i = 32'h8;
        stall_req_i  = 6'b010000;
        settle();
        check_flush("sys.N", 1'b0, 32'h0, 6'b111111);
        cyc();
        excepttype_i = 32'h0;
        stall_req_i  = 6'b000000;
        settle();
        check_flush("sys.N1", 1'b1, 32'h40, 6'b000000);
        cyc();
        stall_req_i = 6'b000100;
        settle();
        check_flush("sys.N2", 1'b0, 32'h0, 6'b000111);
        cyc();
        stall_req_i = 6'b000000;

        // Eret while the bus is busy for three cycles; epc and new causes during drain are ignored.
        cyc();
        excepttype_i = 32'he;
        cp0_epc_i    = 32'hbfc0_0100;
        bus_busy_i   = 1'b1;
        settle();
        check_flush("eret.N", 1'b0, 32'h0, 6'b111111);
        cyc();
        excepttype_i = 32'h1;
        cp0_epc_i    = 32'hdead_beef;
        settle();
        check_flush("eret.drain1", 1'b0, 32'h0, 6'b111111);
        cyc();
        excepttype_i = 32'h0;
        settle();
        check_flush("eret.drain2", 1'b0, 32'h0, 6'b111111);
        cyc();
        bus_busy_i = 1'b0;
        settle();
        check_flush("eret.busy_fell", 1'b0, 32'h0, 6'b111111);
        cyc();
        settle();
        check_flush("eret.flush", 1'b1, 32'hbfc0_0100, 6'b000000);
        cyc();
        settle();
        check_flush("eret.after", 1'b0, 32'h0, 6'b000000);

        // Interrupt followed by an overflow cause that arrives during FLUSH.
        cyc();
        excepttype_i = 32'h1;
        settle();
        check_flush("b2b.N", 1'b0, 32'h0, 6'b111111);
        cyc();
        excepttype_i = 32'hc;
        settle();
        check_flush("b2b.flush", 1'b1, 32'h20, 6'b000000);
        cyc();
        excepttype_i = 32'h0;
        settle();
        check_flush("b2b.N2", 1'b0, 32'h0, 6'b000000);
        cyc();
        settle();
        check_flush("b2b.N3", 1'b0, 32'h0, 6'b000000);

        // Reset during drain aborts the pending flush.
        cyc();
        excepttype_i = 32'hd;
        bus_busy_i   = 1'b1;
        cyc();
        excepttype_i = 32'h0;
        settle();
        check_flush("abort.drain", 1'b0, 32'h0, 6'b111111);
        #1;
        rst_n = 1'b0;
        #1;
        check_flush("abort.reset", 1'b0, 32'h0, 6'b000000);
        cyc();
        rst_n      = 1'b1;
        bus_busy_i = 1'b0;
        settle();
        check_flush("abort.release", 1'b0, 32'h0, 6'b000000);
        cyc();
        settle();
        check_flush("abort.no_flush", 1'b0, 32'h0, 6'b000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
